cekirdek_rv32: RTL and testbench
================================

// Module: cekirdek_rv32
// PURPOSE
//  Single-issue, multi-cycle (non-pipelined) RV32I integer core; top-level processor block of the SoC.
//  Fetches from the L1 instruction memory port (l1b_*) and issues loads/stores on the Memory Operation Unit port (bib_*).
//  Internal: 32x32 register file (x0 hardwired 0), PC, ALU, branch unit, load/store aligner, small FSM.
// PARAMETERS
//  RESET_PC   32'h4000_0000  PC value after reset (first fetch address)
// PORTS
//  clk_i              in   1   clock, all state on rising edge
//  rst_i              in   1   reset, synchronous, active-low (0 = reset)
//  l1b_bekle_i        in   1   instruction memory wait; 1 = l1b_deger_i not valid this cycle
//  l1b_deger_i        in   32  instruction word at l1b_adres_o, valid when l1b_bekle_i=0
//  l1b_adres_o        out  32  instruction fetch byte address (= PC)
//  bib_veri_i         in   32  load data word (word-aligned lanes), valid when bib_durdur_i=0
//  bib_durdur_i       in   1   data-side stall; 1 = current bib access not complete
//  bib_veri_o         out  32  store data, shifted into byte lanes per address[1:0]
//  bib_adr_o          out  32  data byte address (rs1+imm, unmodified)
//  bib_veri_maske_o   out  4   byte-lane enables, bit i = byte lane i
//  bib_yaz_gecerli_o  out  1   1 = store, 0 = load (meaningful only when bib_sec_o=1)
//  bib_sec_o          out  1   data access request
// BEHAVIOUR
//  Reset (rst_i=0 at posedge): PC=RESET_PC, FSM=GETIR, x1..x31=0, bib_sec_o=0, bib_yaz_gecerli_o=0,
//   bib_veri_maske_o=0, bib_adr_o=0, bib_veri_o=0. Reset mid-access aborts it; no register/PC update.
//  FSM states: GETIR -> YURUT -> (BELLEK for load/store) -> GETIR.
//   GETIR: l1b_adres_o=PC; stay while l1b_bekle_i=1 (address held stable); when 0, latch l1b_deger_i into IR, go YURUT.
//   YURUT: decode IR, read rs1/rs2, ALU/branch; non-memory ops write rd, update PC, go GETIR.
//     Load/store: compute address, go BELLEK.
//   BELLEK: bib_sec_o=1, address/mask/data/yaz stable for whole state; stay while bib_durdur_i=1;
//     when 0: load writes rd from bib_veri_i, PC+=4, go GETIR.
//  Latency (no stalls): ALU/branch/jump = 2 cycles, load/store = 3 cycles per instruction.
//  ISA: LUI AUIPC JAL JALR BEQ BNE BLT BGE BLTU BGEU LB LH LW LBU LHU SB SH SW, all OP-IMM and OP (RV32I).
//   Shifts use low 5 bits of shamt/rs2; SRA/SRAI arithmetic. SLT signed, SLTU unsigned. Arithmetic wraps mod 2^32.
//   JAL/JALR: rd=PC+4; JALR target=(rs1+imm)&~1. Taken branch PC=PC+imm_B, else PC+4.
//   FENCE, ECALL, EBREAK, SYSTEM/CSR, unknown opcodes: executed as NOP (PC+=4, no write, no access).
//   Writes to x0 discarded; rd read-after-write visible to next instruction.
//  Lanes: SB mask=1<<a[1:0], data={4{rs2[7:0]}}; SH mask=a[1]?1100:0011, data={2{rs2[15:0]}};
//   SW mask=1111, data=rs2. Loads: mask same rule; byte/half extracted from lane a[1:0]/a[1], sign/zero-extended.
//   Misaligned (half at a[0]=1, word at a[1:0]!=0): no trap; half uses a[1] lane, word uses full word.
//  Outside BELLEK: bib_sec_o=0, bib_yaz_gecerli_o=0, bib_veri_maske_o=0.
//  l1b_bekle_i and bib_durdur_i may hold for any number of cycles; no timeout.
// TESTING
//  1. rst_i=0 two cycles, l1b_bekle_i=0 -> l1b_adres_o=0x4000_0000, bib_sec_o=0, mask=0 after release.
//  2. 0x00500093 (addi x1,x0,5) then 0x00102423 (sw x1,8(x0)) -> bib_sec_o=1, yaz=1, adr=0x8, mask=1111, veri=5.
//  3. x1=5, 0x001000A3 (sb x1,1(x0)) -> adr=0x1, mask=0010, veri=0x0505_0505; PC advances by 4.
//  4. lb x2,1(x0) with bib_veri_i=0x0000_80FF -> x2=0xFFFF_FF80; lbu -> 0x80; store x2 to confirm.
//  5. l1b_bekle_i=1 for 3 cycles -> l1b_adres_o stable; bib_durdur_i=1 4 cycles in store -> outputs held, PC unchanged.
//  6. jal x1,16 at 0x4000_0000 -> next fetch 0x4000_0010, x1=0x4000_0004; beq x0,x0,-4 -> fetch PC-4.

Source files
------------

// File: rtl/cekirdek_rv32.sv
// cekirdek_rv32: multi-cycle RV32I integer core.
// Each instruction walks GETIR -> YURUT (-> BELLEK for loads/stores) -> GETIR.
// The data-side outputs are registered so they stay stable for the whole BELLEK state.
module cekirdek_rv32 #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        l1b_bekle_i,
  input  logic [31:0] l1b_deger_i,
  output logic [31:0] l1b_adres_o,
  input  logic [31:0] bib_veri_i,
  input  logic        bib_durdur_i,
  output logic [31:0] bib_veri_o,
  output logic [31:0] bib_adr_o,
  output logic [3:0]  bib_veri_maske_o,
  output logic        bib_yaz_gecerli_o,
  output logic        bib_sec_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {GETIR, YURUT, BELLEK} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        br_taken;
  logic [31:0] next_pc;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        is_load;
  logic        is_store;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] store_data;
  logic [31:0] lane_word;
  logic [15:0] half_word;
  logic [31:0] load_data;

  assign opcode      = ir[6:0];
  assign funct3      = ir[14:12];
  assign rd          = ir[11:7];
  assign rs1_val     = (ir[19:15] == 5'd0) ? 32'd0 : regs[ir[19:15]];
  assign rs2_val     = (ir[24:20] == 5'd0) ? 32'd0 : regs[ir[24:20]];
  assign imm_i       = {{20{ir[31]}}, ir[31:20]};
  assign imm_s       = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b       = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u       = {ir[31:12], 12'd0};
  assign imm_j       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign l1b_adres_o = pc;

  // Decode, ALU, branch resolution and load/store lane handling for the current IR.
  always_comb begin
    op_b       = (opcode == OPC_OP) ? rs2_val : imm_i;
    alu_res    = 32'd0;
    br_taken   = 1'b0;
    next_pc    = pc + 32'd4;
    wr_en      = 1'b0;
    wr_data    = 32'd0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    mem_addr   = 32'd0;
    mem_mask   = 4'b0000;
    store_data = 32'd0;
    lane_word  = 32'd0;
    half_word  = 16'd0;
    load_data  = 32'd0;

    case (funct3)
      3'b000:  alu_res = (opcode == OPC_OP && ir[30]) ? rs1_val - op_b : rs1_val + op_b;
      3'b001:  alu_res = rs1_val << op_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011:  alu_res = {31'd0, rs1_val < op_b};
      3'b100:  alu_res = rs1_val ^ op_b;
      3'b101:  alu_res = ir[30] ? $unsigned($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
      3'b110:  alu_res = rs1_val | op_b;
      default: alu_res = rs1_val & op_b;
    endcase

    case (funct3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase

    case (opcode)
      OPC_LUI: begin
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OPC_AUIPC: begin
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      OPC_JAL: begin
        wr_en   = 1'b1;
        wr_data = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        wr_en   = 1'b1;
        wr_data = pc + 32'd4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
      end
      OPC_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      OPC_OPIMM, OPC_OP: begin
        wr_en   = 1'b1;
        wr_data = alu_res;
      end
      OPC_LOAD: begin
        is_load = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        is_store = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase

    mem_addr = rs1_val + (is_store ? imm_s : imm_i);
    case (funct3[1:0])
      2'b00:   mem_mask = 4'b0001 << mem_addr[1:0];
      2'b01:   mem_mask = mem_addr[1] ? 4'b1100 : 4'b0011;
      default: mem_mask = 4'b1111;
    endcase
    case (funct3[1:0])
      2'b00:   store_data = {4{rs2_val[7:0]}};
      2'b01:   store_data = {2{rs2_val[15:0]}};
      default: store_data = rs2_val;
    endcase

    lane_word = bib_veri_i >> {bib_adr_o[1:0], 3'b000};
    half_word = bib_adr_o[1] ? bib_veri_i[31:16] : bib_veri_i[15:0];
    case (funct3)
      3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b001:  load_data = {{16{half_word[15]}}, half_word};
      3'b100:  load_data = {24'd0, lane_word[7:0]};
      3'b101:  load_data = {16'd0, half_word};
      default: load_data = bib_veri_i;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= GETIR;
    else        state <= state_next;
  end

  // Next-state logic: wait on fetch, branch to BELLEK only for valid loads/stores, wait on data stall.
  always_comb begin
    state_next = state;
    case (state)
      GETIR:   if (!l1b_bekle_i) state_next = YURUT;
      YURUT:   state_next = (is_load || is_store) ? BELLEK : GETIR;
      BELLEK:  if (!bib_durdur_i) state_next = GETIR;
      default: state_next = GETIR;
    endcase
  end

  // Datapath: IR capture, register writeback, PC update and the registered data-bus request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc                <= RESET_PC;
      ir                <= 32'd0;
      bib_sec_o         <= 1'b0;
      bib_yaz_gecerli_o <= 1'b0;
      bib_veri_maske_o  <= 4'b0000;
      bib_adr_o         <= 32'd0;
      bib_veri_o        <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      case (state)
        GETIR: begin
          if (!l1b_bekle_i) ir <= l1b_deger_i;
        end
        YURUT: begin
          if (is_load || is_store) begin
            bib_sec_o         <= 1'b1;
            bib_yaz_gecerli_o <= is_store;
            bib_adr_o         <= mem_addr;
            bib_veri_maske_o  <= mem_mask;
            if (is_store) bib_veri_o <= store_data;
          end else begin
            pc <= next_pc;
            if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
          end
        end
        BELLEK: begin
          if (!bib_durdur_i) begin
            bib_sec_o         <= 1'b0;
            bib_yaz_gecerli_o <= 1'b0;
            bib_veri_maske_o  <= 4'b0000;
            pc                <= pc + 32'd4;
            if (is_load && rd != 5'd0) regs[rd] <= load_data;
          end
        end
        default: begin
          pc <= pc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cekirdek_rv32.sv
// tb_cekirdek_rv32: directed program bench for the RV32I core, checked through store traffic and fetch addresses.
module tb_cekirdek_rv32;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst_i;
  logic        l1b_bekle_i;
  logic [31:0] l1b_deger_i;
  logic [31:0] l1b_adres_o;
  logic [31:0] bib_veri_i;
  logic        bib_durdur_i;
  logic [31:0] bib_veri_o;
  logic [31:0] bib_adr_o;
  logic [3:0]  bib_veri_maske_o;
  logic        bib_yaz_gecerli_o;
  logic        bib_sec_o;

  logic [31:0] prog [0:63];
  logic [31:0] fetch_idx;
  int total = 0;
  int bad   = 0;

  cekirdek_rv32 #(.RESET_PC(BASE)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .l1b_bekle_i(l1b_bekle_i),
    .l1b_deger_i(l1b_deger_i),
    .l1b_adres_o(l1b_adres_o),
    .bib_veri_i(bib_veri_i),
    .bib_durdur_i(bib_durdur_i),
    .bib_veri_o(bib_veri_o),
    .bib_adr_o(bib_adr_o),
    .bib_veri_maske_o(bib_veri_maske_o),
    .bib_yaz_gecerli_o(bib_yaz_gecerli_o),
    .bib_sec_o(bib_sec_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word-indexed program relative to BASE, NOPs outside it.
  always_comb begin
    fetch_idx   = (l1b_adres_o - BASE) >> 2;
    l1b_deger_i = NOP;
    if (fetch_idx < 32'd64) l1b_deger_i = prog[fetch_idx[5:0]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    rst_i = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic waitAccess(input string tag, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bib_sec_o) found = 1'b1;
    end
    if (!found) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expectAccess(input string tag, input logic exp_yaz, input logic [31:0] exp_adr,
                              input logic [3:0] exp_mask, input logic [31:0] exp_veri,
                              input logic [31:0] rdata, input int stall, input logic [31:0] exp_next);
    bit found;
    bib_veri_i = rdata;
    waitAccess(tag, found);
    if (found) begin
      checkOutput({tag, "_yaz"}, {31'd0, bib_yaz_gecerli_o}, {31'd0, exp_yaz});
      checkOutput({tag, "_adr"}, bib_adr_o, exp_adr);
      checkOutput({tag, "_mask"}, {28'd0, bib_veri_maske_o}, {28'd0, exp_mask});
      if (exp_yaz) checkOutput({tag, "_veri"}, bib_veri_o, exp_veri);
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        checkOutput({tag, "_held_sec"}, {31'd0, bib_sec_o}, 32'd1);
        checkOutput({tag, "_held_adr"}, bib_adr_o, exp_adr);
        checkOutput({tag, "_held_veri"}, bib_veri_o, exp_veri);
        checkOutput({tag, "_held_pc"}, l1b_adres_o, exp_next - 32'd4);
        bib_durdur_i = 1'b0;
      end
      @(negedge clk);
      checkOutput({tag, "_done_sec"}, {31'd0, bib_sec_o}, 32'd0);
      checkOutput({tag, "_next_pc"}, l1b_adres_o, exp_next);
    end
  endtask

  initial begin
    bit found;
    rst_i        = 1'b0;
    l1b_bekle_i  = 1'b0;
    bib_durdur_i = 1'b1;
    bib_veri_i   = 32'd0;
    for (int i = 0; i < 64; i++) prog[i] = NOP;
    prog[0]  = 32'h0050_0093;
    prog[1]  = 32'h0010_2423;
    prog[2]  = 32'h0010_00A3;
    prog[3]  = 32'h0010_0103;
    prog[4]  = 32'h0020_2623;
    prog[5]  = 32'h0010_4183;
    prog[6]  = 32'h0030_2823;
    prog[7]  = 32'hFF80_0213;
    prog[8]  = 32'h4012_5293;
    prog[9]  = 32'h0050_2A23;
    prog[10] = 32'h0012_2333;
    prog[11] = 32'h0012_33B3;
    prog[12] = 32'h4040_8433;
    prog[13] = 32'h0060_2C23;
    prog[14] = 32'h0070_2E23;
    prog[15] = 32'h0280_2023;
    prog[16] = 32'h0073_1463;
    prog[17] = 32'h0000_2023;
    prog[18] = 32'h0020_1503;
    prog[19] = 32'h02A0_2223;
    prog[20] = 32'h0073_0463;
    prog[21] = 32'h0210_2423;

    applyStimulus(2);
    l1b_bekle_i = 1'b1;
    @(negedge clk);
    checkOutput("rst_pc", l1b_adres_o, BASE);
    checkOutput("rst_sec", {31'd0, bib_sec_o}, 32'd0);
    checkOutput("rst_yaz", {31'd0, bib_yaz_gecerli_o}, 32'd0);
    checkOutput("rst_mask", {28'd0, bib_veri_maske_o}, 32'd0);
    checkOutput("rst_adr", bib_adr_o, 32'd0);
    checkOutput("rst_veri", bib_veri_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("fetch_wait_pc", l1b_adres_o, BASE);
    end
    l1b_bekle_i = 1'b0;

    expectAccess("sw_x1_8",   1'b1, 32'h08, 4'b1111, 32'h0000_0005, 32'd0, 4, BASE + 32'h08);
    expectAccess("sb_x1_1",   1'b1, 32'h01, 4'b0010, 32'h0505_0505, 32'd0, 0, BASE + 32'h0C);
    expectAccess("lb_x2",     1'b0, 32'h01, 4'b0010, 32'd0, 32'h0000_80FF, 0, BASE + 32'h10);
    expectAccess("sw_x2",     1'b1, 32'h0C, 4'b1111, 32'hFFFF_FF80, 32'd0, 0, BASE + 32'h14);
    expectAccess("lbu_x3",    1'b0, 32'h01, 4'b0010, 32'd0, 32'h0000_80FF, 0, BASE + 32'h18);
    expectAccess("sw_x3",     1'b1, 32'h10, 4'b1111, 32'h0000_0080, 32'd0, 0, BASE + 32'h1C);
    expectAccess("sw_srai",   1'b1, 32'h14, 4'b1111, 32'hFFFF_FFFC, 32'd0, 0, BASE + 32'h28);
    expectAccess("sw_slt",    1'b1, 32'h18, 4'b1111, 32'h0000_0001, 32'd0, 0, BASE + 32'h38);
    expectAccess("sw_sltu",   1'b1, 32'h1C, 4'b1111, 32'h0000_0000, 32'd0, 0, BASE + 32'h3C);
    expectAccess("sw_sub",    1'b1, 32'h20, 4'b1111, 32'h0000_000D, 32'd0, 0, BASE + 32'h40);
    expectAccess("lh_bne",    1'b0, 32'h02, 4'b1100, 32'd0, 32'h8001_1234, 0, BASE + 32'h4C);
    expectAccess("sw_lh",     1'b1, 32'h24, 4'b1111, 32'hFFFF_8001, 32'd0, 0, BASE + 32'h50);
    expectAccess("sw_beq_nt", 1'b1, 32'h28, 4'b1111, 32'h0000_0005, 32'd0, 0, BASE + 32'h58);

    rst_i = 1'b0;
    for (int i = 0; i < 64; i++) prog[i] = NOP;
    prog[0] = 32'h0100_00EF;
    prog[1] = 32'h0000_2223;
    prog[2] = 32'h0000_2223;
    prog[3] = 32'h0000_2223;
    prog[4] = 32'h0010_2023;
    prog[5] = 32'hFE00_0EE3;
    bib_durdur_i = 1'b0;
    applyStimulus(2);

    expectAccess("jal_link", 1'b1, 32'h00, 4'b1111, BASE + 32'h04, 32'd0, 0, BASE + 32'h14);
    repeat (2) @(negedge clk);
    checkOutput("beq_back_pc", l1b_adres_o, BASE + 32'h10);

    bib_durdur_i = 1'b1;
    waitAccess("loop_sw", found);
    if (found) checkOutput("loop_sw_veri", bib_veri_o, BASE + 32'h04);
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("abort_sec", {31'd0, bib_sec_o}, 32'd0);
    checkOutput("abort_mask", {28'd0, bib_veri_maske_o}, 32'd0);
    checkOutput("abort_adr", bib_adr_o, 32'd0);
    checkOutput("abort_pc", l1b_adres_o, BASE);
    rst_i = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
